rtc_sequencer_fsm: RTL and testbench
====================================

# rtc_sequencer_fsm

Parametrised transfer sequencer for the address/data RTC interface. It issues one register transfer at a time to the RTC bus driver and advances on each `in_flag_done` pulse. It runs the power-up init writes, a continuous display-refresh read loop and the switch-driven configuration read/commit flows. The RTC register map, block lengths and commit commands are parameters, and an optional watchdog recovers from a stalled driver. It sits between the switch inputs and the RTC read/write driver, in the slot of the fixed-map general FSM.

## Interface
- `ADDR_W`, 8: RTC address width.
- `DATA_W`, 8: init data width.
- `N_TIME_REGS`, 7: time/date block length, 1..14.
- `N_TIMER_REGS`, 3: timer block length, 1..14.
- `TIME_BASE`, 8'h21: first time/date address. The block is contiguous.
- `TIMER_BASE`, 8'h41: first timer address. The block is contiguous.
- `CMD_RD`, 8'hF0: read-transfer command.
- `CMD_TIME`, 8'hF1: time transfer/commit command.
- `CMD_TIMER`, 8'hF2: timer transfer/commit command.
- `WDOG_CYC`, 1024: watchdog limit in cycles. Used only with `RTC_WATCHDOG_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. 0 = reset.
- `in_flag_done` in 1: one-cycle pulse from the driver; the current transfer is complete.
- `in_sw` in 3: config switches {sw2,sw1,sw0}.
- `out_funcion_conf` out 3: `in_sw` passed straight through.
- `out_addr_ram_rtc` out ADDR_W: address of the current transfer.
- `out_dato_inicio` out DATA_W: write data. Non-zero only in INIT.
- `out_flag_inicio` out 1: 1 in INIT.
- `out_funcion_w_r` out 1: 1 = write, 0 = read.
- `out_en_funcion_rtc` out 1: transfer request.
- `out_busy_cfg` out 1: 1 in any CFG_* state.
- `out_error` out 1: watchdog error flag. Tied to 0 without the macro.

## Operation
- States: IDLE, INIT, READ, CFG_HOUR, CFG_DATE, CFG_TIMER, WR_TIME, WR_TIMER.
- Each state steps through a list of transfers using an index register. Index width is clog2(max list length + 1).
- A `done` pulse increments the index only while `out_en_funcion_rtc` = 1. Pulses arriving while en = 0 are ignored.
- The index clears synchronously on every state change and on every list restart. It is never cleared by a combinational reset.
- When index = list length, the state is at its end step: en = 0, addr = 0, and the transition is evaluated.

Per-state lists and end-step transitions:
- IDLE: no transfers. Goes to INIT on the next cycle.
- INIT (write, flag_inicio = 1): (02,10), (02,00), (10,D2), (00,00). At the end step, goes to READ.
- READ (read): `CMD_RD`, the time block, then the timer block. Length = 1 + N_TIME_REGS + N_TIMER_REGS.
  - At the end step, `in_sw` = 001 goes to CFG_HOUR, 010 goes to CFG_DATE, 100 goes to CFG_TIMER.
  - Any other `in_sw` value restarts READ at index 0.
- CFG_HOUR (read): `CMD_TIMER`, then the timer block.
- CFG_DATE (read): `CMD_TIME`, the first 3 time regs, `CMD_TIMER`, then the timer block.
- CFG_TIMER (read): `CMD_TIME`, then the time block.
- CFG_* end step:
  - `in_sw` = 000: CFG_HOUR and CFG_DATE go to WR_TIME; CFG_TIMER goes to WR_TIMER.
  - Any other value restarts the same CFG_* state at index 0.
- WR_TIME (write): the time block, then `CMD_TIME`. At the end step, goes to READ.
- WR_TIMER (write): the timer block, then `CMD_TIMER`. At the end step, goes to READ.
- `out_dato_inicio` = 0 outside INIT.
- All address arithmetic is base + offset, truncated to ADDR_W.

## Timing
- Outputs are Moore-style: decoded from the registered state and index, and valid in the same cycle the state is entered.
- Asynchronous reset (`reset` = 0): state = IDLE, index = 0, watchdog counter = 0, error = 0. Every output is 0 except `out_funcion_conf`.
- A `done` pulse in cycle t moves the outputs to the next list entry in cycle t+1.
- The end step lasts exactly one cycle. Index 0 of the next state or restart is presented in cycle t+2.
- `in_sw` is sampled only at the end step. Switch changes mid-list have no effect.
- `reset` asserted mid-transfer aborts immediately. After deassertion the sequence restarts from IDLE and then INIT.

## Configuration
- `RTC_WATCHDOG_EN` defined:
  - A counter runs while en = 1 and clears on each accepted `done`.
  - When the counter reaches `WDOG_CYC`, `out_error` is set, the FSM goes to INIT with index 0, and the counter clears.
  - `out_error` stays set until the first `done` accepted afterwards.
- `RTC_WATCHDOG_EN` not defined: no counter is built, `out_error` = 0, and the FSM waits indefinitely for `done`.

## Test plan
- Reset, then release: all outputs 0 in reset. IDLE for 1 cycle, then INIT presents addr 02, data 10, w_r = 1, flag_inicio = 1, en = 1.
- Four `done` pulses in INIT: addresses 02, 02, 10, 00 with data 10, 00, D2, 00. Then one end cycle with en = 0, then READ addr F0, w_r = 0.
- READ with `in_sw` = 000 and 11 `done` pulses: addr sequence F0, 21..27, 41..43. End cycle, then F0 again.
- `in_sw` = 001 at the READ end step: CFG_HOUR reads F2, 41, 42, 43 and repeats. Set `in_sw` = 000: at its next end step, WR_TIME writes 21..27, F1 with w_r = 1, then returns to READ at F0.
- `in_sw` = 100, then 000: CFG_TIMER reads F1, 21..27, then WR_TIMER writes 41, 42, 43, F2. A `done` pulse during an end cycle is ignored.
- With the macro and `WDOG_CYC` = 16: withhold `done` for 16 cycles in READ. `out_error` = 1 and the FSM restarts INIT at addr 02. The first accepted `done` clears `out_error`.

Source files
------------

// File: rtl/rtc_sequencer_fsm.sv
// rtc_sequencer_fsm
// Transfer sequencer for the address/data RTC interface. Issues one register
// transfer at a time to the RTC bus driver and steps to the next one on each
// accepted completion pulse. It covers the power-up init writes, the display
// refresh read loop, and the switch-driven configuration read/commit flows.
//
// Optional feature: define RTC_WATCHDOG_EN to build a stall watchdog. It
// restarts INIT and raises out_error when the driver stops answering.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   in_flag_done        one-cycle completion pulse from the driver
//   in_sw[2:0]          configuration switches {sw2,sw1,sw0}
//   out_funcion_conf    in_sw passed straight through
//   out_addr_ram_rtc    address of the current transfer (0 when idle)
//   out_dato_inicio     init write data (0 outside INIT)
//   out_flag_inicio     1 while in INIT
//   out_funcion_w_r     1 = write, 0 = read
//   out_en_funcion_rtc  transfer request
//   out_busy_cfg        1 in any CFG_* state
//   out_error           watchdog error flag (0 without RTC_WATCHDOG_EN)
//
// Handshake: out_en_funcion_rtc is the request. A transfer is accepted on any
// cycle where out_en_funcion_rtc = 1 and in_flag_done = 1. Pulses seen while
// the request is low are ignored. The request stays high until that accepting
// cycle.
module rtc_sequencer_fsm #(
  parameter int              ADDR_W       = 8,
  parameter int              DATA_W       = 8,
  parameter int              N_TIME_REGS  = 7,
  parameter int              N_TIMER_REGS = 3,
  parameter logic [ADDR_W-1:0] TIME_BASE  = ADDR_W'(8'h21),
  parameter logic [ADDR_W-1:0] TIMER_BASE = ADDR_W'(8'h41),
  parameter logic [ADDR_W-1:0] CMD_RD     = ADDR_W'(8'hF0),
  parameter logic [ADDR_W-1:0] CMD_TIME   = ADDR_W'(8'hF1),
  parameter logic [ADDR_W-1:0] CMD_TIMER  = ADDR_W'(8'hF2),
  parameter int              WDOG_CYC     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_flag_done,
  input  logic [2:0]        in_sw,
  output logic [2:0]        out_funcion_conf,
  output logic [ADDR_W-1:0] out_addr_ram_rtc,
  output logic [DATA_W-1:0] out_dato_inicio,
  output logic              out_flag_inicio,
  output logic              out_funcion_w_r,
  output logic              out_en_funcion_rtc,
  output logic              out_busy_cfg,
  output logic              out_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_READ, S_CFG_HOUR, S_CFG_DATE, S_CFG_TIMER, S_WR_TIME, S_WR_TIMER
  } state_e;

  // List lengths. CFG_DATE is CMD_TIME + 3 time regs + CMD_TIMER + timer block.
  localparam int LEN_READ  = 1 + N_TIME_REGS + N_TIMER_REGS;
  localparam int LEN_DATE  = 5 + N_TIMER_REGS;
  localparam int LEN_MAX   = (LEN_READ > LEN_DATE) ? LEN_READ : LEN_DATE;
  localparam int IDX_W     = $clog2(LEN_MAX + 1);

  localparam logic [IDX_W-1:0] ONE_I      = IDX_W'(1);
  localparam logic [IDX_W-1:0] T_I        = IDX_W'(N_TIME_REGS);
  localparam logic [IDX_W-1:0] R_I        = IDX_W'(N_TIMER_REGS);
  localparam logic [IDX_W-1:0] LEN_INIT_I = IDX_W'(4);
  localparam logic [IDX_W-1:0] LEN_READ_I = IDX_W'(LEN_READ);
  localparam logic [IDX_W-1:0] LEN_HOUR_I = IDX_W'(1 + N_TIMER_REGS);
  localparam logic [IDX_W-1:0] LEN_DATE_I = IDX_W'(LEN_DATE);
  localparam logic [IDX_W-1:0] LEN_CTIM_I = IDX_W'(1 + N_TIME_REGS);
  localparam logic [IDX_W-1:0] LEN_WTIM_I = IDX_W'(N_TIME_REGS + 1);
  localparam logic [IDX_W-1:0] LEN_WTMR_I = IDX_W'(N_TIMER_REGS + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  len_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;
  logic              wr_c, flag_c, busy_c, en_c, end_c, acc_c;
  logic              wd_fire;

  // Output decode: purely from registered state and index (Moore).
  always_comb begin
    len_c  = '0;
    addr_c = '0;
    data_c = '0;
    wr_c   = 1'b0;
    flag_c = 1'b0;
    busy_c = 1'b0;
    case (state_q)
      S_INIT: begin
        len_c  = LEN_INIT_I;
        wr_c   = 1'b1;
        flag_c = 1'b1;
        case (idx_q)
          IDX_W'(0): begin addr_c = ADDR_W'(8'h02); data_c = DATA_W'(8'h10); end
          IDX_W'(1): begin addr_c = ADDR_W'(8'h02); data_c = DATA_W'(8'h00); end
          IDX_W'(2): begin addr_c = ADDR_W'(8'h10); data_c = DATA_W'(8'hD2); end
          default:   begin addr_c = ADDR_W'(8'h00); data_c = DATA_W'(8'h00); end
        endcase
      end
      S_READ: begin
        len_c = LEN_READ_I;
        if (idx_q == '0)      addr_c = CMD_RD;
        else if (idx_q <= T_I) addr_c = TIME_BASE + ADDR_W'(idx_q - ONE_I);
        else                   addr_c = TIMER_BASE + ADDR_W'(idx_q - ONE_I - T_I);
      end
      S_CFG_HOUR: begin
        len_c  = LEN_HOUR_I;
        busy_c = 1'b1;
        if (idx_q == '0) addr_c = CMD_TIMER;
        else             addr_c = TIMER_BASE + ADDR_W'(idx_q - ONE_I);
      end
      S_CFG_DATE: begin
        len_c  = LEN_DATE_I;
        busy_c = 1'b1;
        if (idx_q == '0)               addr_c = CMD_TIME;
        else if (idx_q <= IDX_W'(3))   addr_c = TIME_BASE + ADDR_W'(idx_q - ONE_I);
        else if (idx_q == IDX_W'(4))   addr_c = CMD_TIMER;
        else                           addr_c = TIMER_BASE + ADDR_W'(idx_q - IDX_W'(5));
      end
      S_CFG_TIMER: begin
        len_c  = LEN_CTIM_I;
        busy_c = 1'b1;
        if (idx_q == '0) addr_c = CMD_TIME;
        else             addr_c = TIME_BASE + ADDR_W'(idx_q - ONE_I);
      end
      S_WR_TIME: begin
        len_c = LEN_WTIM_I;
        wr_c  = 1'b1;
        if (idx_q < T_I) addr_c = TIME_BASE + ADDR_W'(idx_q);
        else             addr_c = CMD_TIME;
      end
      S_WR_TIMER: begin
        len_c = LEN_WTMR_I;
        wr_c  = 1'b1;
        if (idx_q < R_I) addr_c = TIMER_BASE + ADDR_W'(idx_q);
        else             addr_c = CMD_TIMER;
      end
      default: len_c = '0;  // IDLE: empty list, end step right away
    endcase
    en_c  = (idx_q < len_c);
    end_c = (idx_q == len_c);
    // End step presents no transfer.
    if (!en_c) begin
      addr_c = '0;
      data_c = '0;
    end
  end

  assign acc_c = en_c & in_flag_done;

  // Next state / index. in_sw only matters on the end step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (wd_fire) begin
      state_d = S_INIT;
      idx_d   = '0;
    end else if (acc_c) begin
      idx_d = idx_q + ONE_I;
    end else if (end_c) begin
      idx_d = '0;  // both a state change and a restart begin at index 0
      case (state_q)
        S_IDLE: state_d = S_INIT;
        S_INIT: state_d = S_READ;
        S_READ: begin
          case (in_sw)
            3'b001:  state_d = S_CFG_HOUR;
            3'b010:  state_d = S_CFG_DATE;
            3'b100:  state_d = S_CFG_TIMER;
            default: state_d = S_READ;
          endcase
        end
        S_CFG_HOUR, S_CFG_DATE: if (in_sw == 3'b000) state_d = S_WR_TIME;
        S_CFG_TIMER:            if (in_sw == 3'b000) state_d = S_WR_TIMER;
        default:                state_d = S_READ;  // WR_TIME / WR_TIMER
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RTC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;

  // Fires on the cycle that would bring the stall count to WDOG_CYC.
  always_comb begin
    wd_fire  = en_c & ~in_flag_done & (wd_cnt_q == WD_W'(WDOG_CYC - 1));
    wd_cnt_d = wd_cnt_q + WD_W'(1);
    if (!en_c || in_flag_done || wd_fire) wd_cnt_d = '0;
    err_d = err_q;
    if (wd_fire)    err_d = 1'b1;
    else if (acc_c) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign out_error = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC == 0);
  assign wd_fire     = 1'b0;
  assign out_error   = 1'b0;
`endif

  assign out_funcion_conf   = in_sw;
  assign out_addr_ram_rtc   = addr_c;
  assign out_dato_inicio    = data_c;
  assign out_flag_inicio    = flag_c;
  assign out_funcion_w_r    = wr_c;
  assign out_en_funcion_rtc = en_c;
  assign out_busy_cfg       = busy_c;

endmodule

// File: tb/tb_rtc_sequencer_fsm.sv
// Bench for rtc_sequencer_fsm. A reference model keeps the current transfer
// list (built from the register map) in exp_q and a position into it; every
// cycle the DUT outputs are compared with the list entry the model expects.
module tb_rtc_sequencer_fsm;
  localparam int T  = 7;
  localparam int R  = 3;
  localparam int WD = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_flag_done;
  logic [2:0] in_sw;
  logic [2:0] out_funcion_conf;
  logic [7:0] out_addr_ram_rtc;
  logic [7:0] out_dato_inicio;
  logic       out_flag_inicio, out_funcion_w_r, out_en_funcion_rtc;
  logic       out_busy_cfg, out_error;

  rtc_sequencer_fsm #(
    .ADDR_W(8), .DATA_W(8), .N_TIME_REGS(T), .N_TIMER_REGS(R),
    .TIME_BASE(8'h21), .TIMER_BASE(8'h41), .CMD_RD(8'hF0),
    .CMD_TIME(8'hF1), .CMD_TIMER(8'hF2), .WDOG_CYC(WD)
  ) dut (
    .clk(clk), .reset(reset), .in_flag_done(in_flag_done), .in_sw(in_sw),
    .out_funcion_conf(out_funcion_conf), .out_addr_ram_rtc(out_addr_ram_rtc),
    .out_dato_inicio(out_dato_inicio), .out_flag_inicio(out_flag_inicio),
    .out_funcion_w_r(out_funcion_w_r), .out_en_funcion_rtc(out_en_funcion_rtc),
    .out_busy_cfg(out_busy_cfg), .out_error(out_error)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model
  logic [7:0] exp_q[$];
  logic [7:0] dat_q[$];
  string      m_name;
  int         m_pos, m_wcnt, m_loads;
  bit         m_wr, m_flag, m_busy, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_time();
    for (int i = 0; i < T; i++) exp_q.push_back(8'(8'h21 + i));
  endtask

  task automatic push_timer();
    for (int i = 0; i < R; i++) exp_q.push_back(8'(8'h41 + i));
  endtask

  task automatic load(input string n);
    exp_q.delete();
    dat_q.delete();
    m_wr = 0; m_flag = 0; m_busy = 0;
    m_pos = 0; m_name = n; m_loads++;
    if (n == "INIT") begin
      exp_q = '{8'h02, 8'h02, 8'h10, 8'h00};
      dat_q = '{8'h10, 8'h00, 8'hD2, 8'h00};
      m_wr = 1; m_flag = 1;
    end else if (n == "READ") begin
      exp_q.push_back(8'hF0); push_time(); push_timer();
    end else if (n == "CFG_HOUR") begin
      exp_q.push_back(8'hF2); push_timer(); m_busy = 1;
    end else if (n == "CFG_DATE") begin
      exp_q = '{8'hF1, 8'h21, 8'h22, 8'h23, 8'hF2}; push_timer(); m_busy = 1;
    end else if (n == "CFG_TIMER") begin
      exp_q.push_back(8'hF1); push_time(); m_busy = 1;
    end else if (n == "WR_TIME") begin
      push_time(); exp_q.push_back(8'hF1); m_wr = 1;
    end else if (n == "WR_TIMER") begin
      push_timer(); exp_q.push_back(8'hF2); m_wr = 1;
    end
  endtask

  function automatic string next_name(input string n, input logic [2:0] sw);
    if (n == "IDLE") return "INIT";
    if (n == "INIT") return "READ";
    if (n == "READ") begin
      if (sw == 3'b001) return "CFG_HOUR";
      if (sw == 3'b010) return "CFG_DATE";
      if (sw == 3'b100) return "CFG_TIMER";
      return "READ";
    end
    if (n == "CFG_HOUR" || n == "CFG_DATE") return (sw == 3'b000) ? "WR_TIME" : n;
    if (n == "CFG_TIMER") return (sw == 3'b000) ? "WR_TIMER" : n;
    return "READ";
  endfunction

  // driver: called at a negedge; drives inputs, checks, advances the model
  task automatic step(input logic d, input logic [2:0] sw);
    bit en_e;
    in_flag_done = d;
    in_sw        = sw;
    #1;
    en_e = (m_pos < exp_q.size());
    chk({m_name, ".en"},   32'(out_en_funcion_rtc), 32'(en_e));
    chk({m_name, ".addr"}, 32'(out_addr_ram_rtc),   en_e ? 32'(exp_q[m_pos]) : 32'h0);
    if (en_e) begin
      chk({m_name, ".w_r"},  32'(out_funcion_w_r), 32'(m_wr));
      chk({m_name, ".data"}, 32'(out_dato_inicio), m_flag ? 32'(dat_q[m_pos]) : 32'h0);
    end
    chk({m_name, ".flag"}, 32'(out_flag_inicio),  32'(m_flag));
    chk({m_name, ".busy"}, 32'(out_busy_cfg),     32'(m_busy));
    chk({m_name, ".err"},  32'(out_error),        32'(m_err));
    chk({m_name, ".conf"}, 32'(out_funcion_conf), 32'(sw));
    if (en_e && d) begin
      m_pos++; m_err = 0; m_wcnt = 0;
    end else if (en_e) begin
`ifdef RTC_WATCHDOG_EN
      m_wcnt++;
      if (m_wcnt == WD) begin
        m_wcnt = 0; m_err = 1; load("INIT");
      end
`endif
    end else begin
      load(next_name(m_name, sw));
    end
    @(negedge clk);
  endtask

  // Run until n lists have been (re)started. Mid-list switches are random;
  // at each end step the switches take `steer` and a done pulse is offered.
  task automatic run_lists(input int n, input logic [2:0] steer, input int budget);
    int target, cyc;
    bit at_end;
    target = m_loads + n;
    cyc = 0;
    while (m_loads < target && cyc < budget) begin
      at_end = (m_pos >= exp_q.size());
      step(at_end ? 1'b1 : 1'($urandom_range(0, 99) < 55),
           at_end ? steer : 3'($urandom_range(0, 7)));
      cyc++;
    end
    if (m_loads < target) begin
      tests_run++;
      tests_failed++;
      $error("FAIL run_lists timeout in %s: observed=%0d lists expected=%0d", m_name, m_loads, target);
    end
  endtask

  task automatic chk_all_zero(input string tag, input logic [2:0] sw);
    chk({tag, ".en"},   32'(out_en_funcion_rtc), 32'h0);
    chk({tag, ".addr"}, 32'(out_addr_ram_rtc),   32'h0);
    chk({tag, ".data"}, 32'(out_dato_inicio),    32'h0);
    chk({tag, ".w_r"},  32'(out_funcion_w_r),    32'h0);
    chk({tag, ".flag"}, 32'(out_flag_inicio),    32'h0);
    chk({tag, ".busy"}, 32'(out_busy_cfg),       32'h0);
    chk({tag, ".err"},  32'(out_error),          32'h0);
    chk({tag, ".conf"}, 32'(out_funcion_conf),   32'(sw));
  endtask

  logic [2:0] sw_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};

  initial begin
    m_loads = 0; m_wcnt = 0; m_err = 0;
    reset = 1'b0;
    in_flag_done = 1'b0;
    in_sw = 3'b101;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset", 3'b101);

    reset = 1'b1;
    load("IDLE");
    run_lists(1, 3'b000, 5);     // IDLE -> INIT
    run_lists(1, 3'b000, 60);    // INIT -> READ
    run_lists(2, 3'b000, 120);   // READ restarts
    run_lists(1, 3'b001, 60);    // -> CFG_HOUR
    run_lists(2, 3'b011, 60);    // CFG_HOUR restarts
    run_lists(1, 3'b000, 60);    // -> WR_TIME
    run_lists(1, 3'b110, 60);    // -> READ
    run_lists(1, 3'b010, 60);    // -> CFG_DATE
    run_lists(1, 3'b101, 60);    // CFG_DATE restart
    run_lists(1, 3'b000, 60);    // -> WR_TIME
    run_lists(1, 3'b000, 60);    // -> READ
    run_lists(1, 3'b100, 60);    // -> CFG_TIMER
    run_lists(1, 3'b100, 60);    // CFG_TIMER restart
    run_lists(1, 3'b000, 60);    // -> WR_TIMER
    run_lists(1, 3'b000, 60);    // -> READ

    for (int k = 0; k < 12; k++)
      run_lists(1, sw_tab[$urandom_range(0, 4)], 80);

    // Stall the driver with a transfer pending.
    while (m_pos >= exp_q.size()) step(1'b0, 3'b000);
    for (int i = 0; i < 40; i++) step(1'b0, 3'($urandom_range(0, 7)));
    run_lists(2, 3'b000, 120);

    // Asynchronous reset in the middle of a transfer.
    run_lists(1, 3'b000, 60);
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    @(posedge clk);
    #3;
    reset = 1'b0;
    in_flag_done = 1'b0;
    in_sw = 3'b011;
    #1;
    chk_all_zero("midreset", 3'b011);
    @(negedge clk);
    reset = 1'b1;
    m_wcnt = 0; m_err = 0;
    load("IDLE");
    run_lists(3, 3'b000, 120);   // IDLE -> INIT -> READ -> READ

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
